// File: rtl/target_div_sequencer.sv
// target_div_sequencer
// Computes the two divider multipliers C_N1/C_N2 from the crystal ratio C_RX
// and the packed dual target word C_N, using one shared 32-bit restoring
// divider time-shared over four 33-cycle divisions.
//
// Ports:
//   Clk    in   clock, rising edge
//   Reset  in   asynchronous active-low reset
//   En     in   block enable; low aborts a running computation
//   Start  in   request pulse, accepted only in IDLE with En high
//   C_RX   in   [31:0] crystal ratio x100
//   C_N    in   [31:0] {int2[8:0], frac2[6:0], int1[8:0], frac1[6:0]}
//   Busy   out  high while a computation runs
//   Done   out  one-cycle pulse when C_N1/C_N2 update
//   C_N1   out  [31:0] {integer[24:0], hundredths[6:0]} for channel 1
//   C_N2   out  [31:0] same for channel 2
//   Err    out  [1:0] sticky divide-by-zero flags {ch2, ch1}
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for Start
// ST_DIV_I1 | ringSpd / dvs1 -> integer part 1, remainder 1
// ST_DIV_F1 | (rem1 * FRAC_SCALE) / dvs1 -> fraction part 1
// ST_DIV_I2 | ringSpd / dvs2 -> integer part 2, remainder 2
// ST_DIV_F2 | (rem2 * FRAC_SCALE) / dvs2 -> fraction part 2
// ST_DONE   | publish results, pulse Done

module target_div_sequencer #(
  parameter int XTAL_SPD   = 45,
  parameter int FRAC_SCALE = 100
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        En,
  input  logic        Start,
  input  logic [31:0] C_RX,
  input  logic [31:0] C_N,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] C_N1,
  output logic [31:0] C_N2,
  output logic [1:0]  Err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DIV_I1, ST_DIV_F1, ST_DIV_I2, ST_DIV_F2, ST_DONE
  } state_t;

  localparam logic [31:0] LP_XTAL  = 32'(XTAL_SPD);
  localparam logic [31:0] LP_SCALE = 32'(FRAC_SCALE);

  state_t      r_state, w_state_nxt;
  logic        w_busy_nxt;
  logic [5:0]  r_step;
  logic [31:0] r_ring;
  logic [15:0] r_dvs1, r_dvs2;
  logic [31:0] r_dvd, r_quo, r_rem;
  logic [24:0] r_int1, r_int2;
  logic [6:0]  r_flt1, r_flt2;

  logic [31:0] w_ring;
  logic [15:0] w_dvs1, w_dvs2;
  logic        w_last, w_ch1, w_frac_step, w_zero1, w_zero2;
  logic [31:0] w_dvs, w_dvd_load, w_quo_nxt;
  logic [32:0] w_trial, w_diff;
  logic        w_qbit;

  assign w_ring = C_RX * LP_XTAL;
  assign w_dvs1 = 16'(C_N[15:7]) * LP_SCALE[15:0] + 16'(C_N[6:0]);
  assign w_dvs2 = 16'(C_N[31:23]) * LP_SCALE[15:0] + 16'(C_N[22:16]);

  assign w_last      = (r_step == 6'd32);
  assign w_ch1       = (r_state == ST_DIV_I1) || (r_state == ST_DIV_F1);
  assign w_frac_step = (r_state == ST_DIV_F1) || (r_state == ST_DIV_F2);
  assign w_zero1     = (r_dvs1 == 16'd0);
  assign w_zero2     = (r_dvs2 == 16'd0);
  assign w_dvs       = w_ch1 ? {16'd0, r_dvs1} : {16'd0, r_dvs2};
  // The fraction step reuses the remainder left in r_rem by the integer step.
  assign w_dvd_load  = w_frac_step ? (r_rem * LP_SCALE) : r_ring;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", so the quotient saturates to all ones.
  assign w_trial   = {r_rem, r_dvd[31]};
  assign w_diff    = w_trial - {1'b0, w_dvs};
  assign w_qbit    = ~w_diff[32];
  assign w_quo_nxt = {r_quo[30:0], w_qbit};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (En && Start) w_state_nxt = ST_DIV_I1;
      ST_DIV_I1: if (!En) w_state_nxt = ST_IDLE; else if (w_last) w_state_nxt = ST_DIV_F1;
      ST_DIV_F1: if (!En) w_state_nxt = ST_IDLE; else if (w_last) w_state_nxt = ST_DIV_I2;
      ST_DIV_I2: if (!En) w_state_nxt = ST_IDLE; else if (w_last) w_state_nxt = ST_DIV_F2;
      ST_DIV_F2: if (!En) w_state_nxt = ST_IDLE; else if (w_last) w_state_nxt = ST_DONE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == ST_DIV_I1) || (w_state_nxt == ST_DIV_F1) ||
                 (w_state_nxt == ST_DIV_I2) || (w_state_nxt == ST_DIV_F2);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_step <= '0;
      r_ring <= '0;
      r_dvs1 <= '0;
      r_dvs2 <= '0;
      r_dvd  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_int1 <= '0;
      r_int2 <= '0;
      r_flt1 <= '0;
      r_flt2 <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      C_N1   <= '0;
      C_N2   <= '0;
      Err    <= '0;
    end else begin
      Busy <= w_busy_nxt;
      Done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_step <= '0;
          if (En && Start) begin
            r_ring <= w_ring;
            r_dvs1 <= w_dvs1;
            r_dvs2 <= w_dvs2;
            Err    <= '0;
          end
        end
        ST_DONE: begin
          if (En) begin
            C_N1 <= w_zero1 ? 32'hFFFF_FFFF : {r_int1, r_flt1};
            C_N2 <= w_zero2 ? 32'hFFFF_FFFF : {r_int2, r_flt2};
            Err  <= {w_zero2, w_zero1};
            Done <= 1'b1;
          end
        end
        default: begin
          if (!En) begin
            r_step <= '0;
          end else if (r_step == 6'd0) begin
            r_dvd  <= w_dvd_load;
            r_quo  <= '0;
            r_rem  <= '0;
            r_step <= 6'd1;
          end else begin
            r_dvd <= {r_dvd[30:0], 1'b0};
            r_quo <= w_quo_nxt;
            r_rem <= w_qbit ? w_diff[31:0] : w_trial[31:0];
            if (w_last) begin
              r_step <= '0;
              case (r_state)
                ST_DIV_I1: r_int1 <= w_quo_nxt[24:0];
                ST_DIV_F1: r_flt1 <= w_zero1 ? 7'd0 : w_quo_nxt[6:0];
                ST_DIV_I2: r_int2 <= w_quo_nxt[24:0];
                ST_DIV_F2: r_flt2 <= w_zero2 ? 7'd0 : w_quo_nxt[6:0];
                default: ;
              endcase
            end else begin
              r_step <= r_step + 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_target_div_sequencer.sv
// Directed bench for target_div_sequencer: reset, three nominal calculations,
// divide-by-zero, Start while busy, En abort and mid-operation reset.

module tb_target_div_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        En = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] C_RX = '0;
  logic [31:0] C_N = '0;
  logic        Busy, Done;
  logic [31:0] C_N1, C_N2;
  logic [1:0]  Err;

  int n_assert = 0;
  int n_fail   = 0;

  target_div_sequencer #(.XTAL_SPD(45), .FRAC_SCALE(100)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Start(Start),
    .C_RX(C_RX), .C_N(C_N),
    .Busy(Busy), .Done(Done), .C_N1(C_N1), .C_N2(C_N2), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"}, 32'(Busy), 32'd0);
    chk({tag, ".done"}, 32'(Done), 32'd0);
    chk({tag, ".cn1"},  C_N1, 32'd0);
    chk({tag, ".cn2"},  C_N2, 32'd0);
    chk({tag, ".err"},  32'(Err), 32'd0);
  endtask

  // Launch one computation and watch it for a fixed 150-cycle window.
  // Sample index i is taken 1 ns after the i-th rising edge following the
  // Start-sampling edge (i = 0 is just after that edge).
  task automatic run_op(input logic [31:0] rx, input logic [31:0] cn,
                        input logic [31:0] cn_alt, input int pulse_at,
                        input int en_drop_at, output int done_idx,
                        output int busy_cnt, output int done_cnt);
    @(negedge Clk);
    C_RX  = rx;
    C_N   = cn;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start    = 1'b0;
    done_idx = -1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (i > 0) begin
        @(posedge Clk);
        #1;
      end
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (i == pulse_at) begin
        C_N   = cn_alt;
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      if (i == en_drop_at) En = 1'b0;
    end
    En    = 1'b1;
    Start = 1'b0;
  endtask

  int d_idx, b_cnt, d_cnt;

  initial begin
    // 1: reset, then idle
    #1;
    chk_idle_zero("t1.in_reset");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      chk_idle_zero("t1.idle");
    end

    // 2: 11250/1750 = 6 r750 -> .42 ; 11250/2563 = 4 r998 -> .38
    run_op(32'd250, 32'h0CBF08B2, 32'h0, -1, -1, d_idx, b_cnt, d_cnt);
    chk("t2.done_idx", 32'(d_idx), 32'd133);
    chk("t2.busy_cnt", 32'(b_cnt), 32'd132);
    chk("t2.done_cnt", 32'(d_cnt), 32'd1);
    chk("t2.cn1", C_N1, 32'h0000032A);
    chk("t2.cn2", C_N2, 32'h00000226);
    chk("t2.err", 32'(Err), 32'd0);

    // 3: 9000/5050 = 1 r3950 -> .78 ; 9000/10000 = 0 r9000 -> .90
    run_op(32'd200, 32'h32001932, 32'h0, -1, -1, d_idx, b_cnt, d_cnt);
    chk("t3.done_idx", 32'(d_idx), 32'd133);
    chk("t3.done_cnt", 32'(d_cnt), 32'd1);
    chk("t3.cn1", C_N1, 32'h000000CE);
    chk("t3.cn2", C_N2, 32'h0000005A);
    chk("t3.err", 32'(Err), 32'd0);

    // 4: channel 1 divisor zero
    run_op(32'd250, 32'h0CBF0000, 32'h0, -1, -1, d_idx, b_cnt, d_cnt);
    chk("t4.done_idx", 32'(d_idx), 32'd133);
    chk("t4.busy_cnt", 32'(b_cnt), 32'd132);
    chk("t4.cn1", C_N1, 32'hFFFFFFFF);
    chk("t4.cn2", C_N2, 32'h00000226);
    chk("t4.err", 32'(Err), 32'd1);

    // 5: new C_N and Start pulse at cycle 40 are ignored
    run_op(32'd250, 32'h0CBF08B2, 32'h32001932, 40, -1, d_idx, b_cnt, d_cnt);
    chk("t5.done_idx", 32'(d_idx), 32'd133);
    chk("t5.done_cnt", 32'(d_cnt), 32'd1);
    chk("t5.cn1", C_N1, 32'h0000032A);
    chk("t5.cn2", C_N2, 32'h00000226);
    chk("t5.err", 32'(Err), 32'd0);

    // 6a: En dropped at cycle 70 aborts; results from test 5 remain
    run_op(32'd200, 32'h32001932, 32'h0, -1, 70, d_idx, b_cnt, d_cnt);
    chk("t6a.busy_cnt", 32'(b_cnt), 32'd71);
    chk("t6a.done_cnt", 32'(d_cnt), 32'd0);
    chk("t6a.busy_end", 32'(Busy), 32'd0);
    chk("t6a.cn1", C_N1, 32'h0000032A);
    chk("t6a.cn2", C_N2, 32'h00000226);

    // 6b: reset at cycle 50 clears everything at once
    @(negedge Clk);
    C_RX  = 32'd200;
    C_N   = 32'h32001932;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    chk("t6b.busy_running", 32'(Busy), 32'd1);
    repeat (50) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk_idle_zero("t6b.reset");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    d_cnt = 0;
    for (int i = 0; i < 140; i++) begin
      @(posedge Clk);
      #1;
      if (Done || Busy) d_cnt++;
    end
    chk("t6b.no_activity", 32'(d_cnt), 32'd0);
    chk_idle_zero("t6b.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/target_div_sequencer.md
Name: target_div_sequencer

Overview:
Sequential replacement for the combinational multiplier calculator. It computes the two divider multipliers C_N1 and C_N2 from the crystal ratio C_RX and the packed dual target word C_N. A single shared 32-bit restoring divider is time-shared across four divisions. A Start/Busy/Done handshake sits between the top-level configuration logic and the Divider modules.

Parameters:
XTAL_SPD, 45, crystal speed multiplier; ringSpd = C_RX*XTAL_SPD, truncated to 32 bits.
FRAC_SCALE, 100, fixed-point fraction scale applied to target fractions and remainders.

Ports:
Clk  in  1  clock, all state on rising edge.
Reset  in  1  asynchronous, active-low reset.
En  in  1  block enable; low aborts any operation.
Start  in  1  request pulse; sampled only in IDLE with En=1.
C_RX  in  32  crystal ratio ×100.
C_N  in  32  packed targets: [31:23] int2, [22:16] frac2, [15:7] int1, [6:0] frac1.
Busy  out  1  high while a computation is in progress.
Done  out  1  one-cycle pulse when C_N1/C_N2 update.
C_N1  out  32  multiplier 1: [31:7] integer, [6:0] fraction (hundredths).
C_N2  out  32  multiplier 2, same format.
Err  out  2  sticky divide-by-zero flags; bit0 = channel 1, bit1 = channel 2.

Behaviour:
- Reset low (async): state IDLE; Busy=0, Done=0, C_N1=0, C_N2=0, Err=0; all internal registers 0.
- Start sample: in IDLE, En=1 and Start=1 at an edge. At that edge:
  - latch ringSpd = C_RX*XTAL_SPD.
  - latch dvs1 = C_N[15:7]*FRAC_SCALE + C_N[6:0].
  - latch dvs2 = C_N[31:23]*FRAC_SCALE + C_N[22:16].
  - clear Err.
  - enter DIV_I1; Busy=1 from the next cycle.
- Later input changes have no effect on the running computation.
- States: IDLE -> DIV_I1 -> DIV_F1 -> DIV_I2 -> DIV_F2 -> DONE -> IDLE.
- Each DIV state is 33 cycles: step 0 loads dividend/divisor and clears the quotient and partial remainder; steps 1..32 run one restoring shift-subtract bit per cycle, MSB first. A 6-bit step counter controls exit.
- DIV_I1: intF1 = ringSpd/dvs1, rem1 = ringSpd mod dvs1.
- DIV_F1: fltF1 = (rem1*FRAC_SCALE)/dvs1. rem*100 < 5,122,700, so it fits in 32 bits with no overflow.
- DIV_I2 and DIV_F2: same as DIV_I1/DIV_F1 using dvs2.
- DONE (one cycle):
  - C_N1 = {intF1[24:0], fltF1[6:0]}; C_N2 = {intF2[24:0], fltF2[6:0]}.
  - Done=1, Busy=0. Next state IDLE.
- Latency: Done is high in the cycle following the 133rd rising edge after the Start-sampling edge. Busy is high for exactly 132 cycles.
- Divide-by-zero (dvsN==0):
  - both divisions of that channel still consume 33 cycles each, keeping latency fixed.
  - quotient forced to 32'hFFFFFFFF for the integer step and 0 for the fraction step.
  - C_Nx = 32'hFFFFFFFF at DONE; Err[x] set, held until the next accepted Start.
- Start while Busy or in DONE: ignored; no queuing.
- Start with En=0: ignored.
- En falling mid-operation (any DIV state or DONE): next edge returns to IDLE with Busy=0 and no Done. C_N1, C_N2 and Err keep their previous values.
- Reset mid-operation: immediate return to reset values.
- Outputs change only at DONE or reset; they hold stable between computations.
- Integer quotient bits above [24:0] are discarded silently.

Test Plan:
1. Reset low, then high, Start idle for 5 cycles -> C_N1=0, C_N2=0, Busy=0, Done=0, Err=0 throughout.
2. C_RX=250, C_N=32'h0CBF08B2 (17.50 / 25.63), Start 1 cycle -> Busy high 132 cycles, then Done pulse with C_N1=32'h0000032A (6.42), C_N2=32'h00000226 (4.38), Err=0.
3. C_RX=200, C_N=32'h32001932 (50.50 / 100.00), Start -> C_N1=32'h000000CE (1.78), C_N2=32'h0000005A (0.90).
4. C_RX=250, C_N=32'h0CBF0000 (channel 1 divisor 0), Start -> C_N1=32'hFFFFFFFF, C_N2=32'h00000226, Err=2'b01, latency still 133 cycles.
5. Start as in test 2; change C_N and pulse Start at cycle 40 -> results identical to test 2, with a single Done pulse.
6. Complete test 2, then Start test 3 and drop En at cycle 70 -> Busy falls next cycle, no Done, C_N1/C_N2 remain 32'h32A/32'h226. Then repeat test 3 with Reset pulsed at cycle 50 -> all outputs 0 immediately.
